tagged_mem_responder: RTL

Synthesizable responder end of the processor-to-memory bus. It accepts BUS_LOAD/BUS_STORE commands from the core and issues a tag in the same cycle. After a fixed latency it returns load data with that tag. It replaces the behavioural memory model for FPGA/synthesis runs and sits directly on the core's proc2mem/mem2proc ports.

---
 rtl/mem_bus_pkg.sv | 36 +++
 rtl/mem_tag_tracker.sv | 78 +++++++
 rtl/tagged_mem_responder.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared processor-to-memory bus definitions: command and size encodings,
// tag and line widths, and the byte-lane enable helper used for stores.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_command_e;

    typedef enum logic [1:0] {
        BYTE   = 2'd0,
        HALF   = 2'd1,
        WORD   = 2'd2,
        DOUBLE = 2'd3
    } mem_size_e;

    localparam int TAG_W  = 4;
    localparam int LINE_W = 64;
    localparam int CNT_W  = 6;

    // Byte lanes touched by an access of the given size; offset bits below
    // the access size are ignored so the lanes are always naturally aligned.
    function automatic logic [7:0] byte_enable(input logic [1:0] size,
                                               input logic [2:0] offset);
        logic [7:0] be;
        case (mem_size_e'(size))
            BYTE:    be = 8'b0000_0001 << offset;
            HALF:    be = 8'b0000_0011 << {offset[2:1], 1'b0};
            WORD:    be = 8'b0000_1111 << {offset[2], 2'b00};
            default: be = 8'b1111_1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_tag_tracker.sv
// Tag slot bookkeeping for the memory responder: per-slot busy flag and
// countdown, lowest-free grant encoder and lowest-ready completion select.
// Tags are 1..NUM_TAGS; a tag value of 0 always means "none".
module mem_tag_tracker
    import mem_bus_pkg::*;
#(
    parameter int NUM_TAGS = 15,
    parameter int LATENCY  = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,        // a real command is presented this cycle
    input  logic [2:0]       jitter_i,     // extra countdown cycles (0 when jitter is off)
    output logic [TAG_W-1:0] grant_tag_o,  // tag accepted this cycle, 0 = rejected
    output logic [TAG_W-1:0] done_tag_o    // tag completing at the next edge, 0 = none
);

    logic [NUM_TAGS:1] busy_q, busy_d;
    logic [CNT_W-1:0]  cnt_q [1:NUM_TAGS];
    logic [CNT_W-1:0]  cnt_d [1:NUM_TAGS];
    logic [TAG_W-1:0]  free_tag;
    logic [CNT_W-1:0]  load_cnt;

    // Countdown start value; it reaches 0 LATENCY-1 edges after acceptance,
    // so the tag is registered onto the bus LATENCY edges after acceptance.
    assign load_cnt = CNT_W'(LATENCY - 1) + CNT_W'(jitter_i);

    // Lowest free slot and lowest ready slot, both from registered state only,
    // so a slot freed at an edge is never re-granted in that same cycle.
    always_comb begin
        free_tag   = '0;
        done_tag_o = '0;
        for (int i = NUM_TAGS; i >= 1; i--) begin
            if (!busy_q[i]) begin
                free_tag = TAG_W'(i);
            end
            if (busy_q[i] && (cnt_q[i] == '0)) begin
                done_tag_o = TAG_W'(i);
            end
        end
        grant_tag_o = (req_i && !rst_i) ? free_tag : '0;
    end

    // Next slot state: grant claims a slot, completion releases one, and
    // non-zero countdowns tick toward zero and then hold.
    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i <= NUM_TAGS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
            if (done_tag_o == TAG_W'(i)) begin
                busy_d[i] = 1'b0;
            end
            if (grant_tag_o == TAG_W'(i)) begin
                busy_d[i] = 1'b1;
                cnt_d[i]  = load_cnt;
            end
        end
    end

    // Slot state registers; reset discards every in-flight tag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= '0;
            for (int i = 1; i <= NUM_TAGS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            for (int i = 1; i <= NUM_TAGS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: rtl/tagged_mem_responder.sv
// Synthesizable responder on the proc2mem/mem2proc bus. Holds the line array,
// store lane logic, per-tag load data and the registered completion outputs.
// Optional macro MEM_LATENCY_JITTER_EN adds 0..7 cycles of LFSR-driven jitter
// to each transaction's latency, so returns may come back out of order.
//
// Handshake: a BUS_LOAD/BUS_STORE command is a request; a non-zero
// mem2proc_response in that same cycle means it was accepted with that tag,
// a zero response means it was not and the core must present it again.
// A non-zero mem2proc_tag is a one-cycle completion with mem2proc_data.
module tagged_mem_responder
    import mem_bus_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int LATENCY   = 10,
    parameter int MEM_LINES = 8192,
    parameter int NUM_TAGS  = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        proc2mem_command,
    input  logic [XLEN-1:0]   proc2mem_addr,
    input  logic [LINE_W-1:0] proc2mem_data,
    input  logic [1:0]        proc2mem_size,
    output logic [TAG_W-1:0]  mem2proc_response,
    output logic [LINE_W-1:0] mem2proc_data,
    output logic [TAG_W-1:0]  mem2proc_tag
);

    localparam int IDX_W = $clog2(MEM_LINES);

    logic [LINE_W-1:0] mem_q       [MEM_LINES];
    logic [LINE_W-1:0] slot_data_q [1:NUM_TAGS];

    logic              cmd_valid;
    logic              is_store;
    logic              accept;
    logic [XLEN-4:0]   line_addr;
    logic              in_range;
    logic [IDX_W-1:0]  mem_idx;
    logic [LINE_W-1:0] rd_line;
    logic [7:0]        be;
    logic [2:0]        jitter;
    logic [TAG_W-1:0]  grant_tag;
    logic [TAG_W-1:0]  done_tag;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [LINE_W-1:0] data_q, data_d;

    // Command value 3 falls through as "no command".
    assign cmd_valid = (proc2mem_command == BUS_LOAD) || (proc2mem_command == BUS_STORE);
    assign is_store  = (proc2mem_command == BUS_STORE);
    assign accept    = (grant_tag != '0);

    // Out-of-range lines read as zero and swallow stores rather than aliasing.
    assign line_addr = proc2mem_addr[XLEN-1:3];
    assign in_range  = ({3'b000, line_addr} < XLEN'(MEM_LINES));
    assign mem_idx   = line_addr[IDX_W-1:0];
    assign rd_line   = in_range ? mem_q[mem_idx] : '0;
    assign be        = byte_enable(proc2mem_size, proc2mem_addr[2:0]);

`ifdef MEM_LATENCY_JITTER_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR, taps 16,14,13,11, stepping every cycle.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // LFSR register, reseeded on reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Note: with LATENCY above 57 the jittered start value wraps the 6-bit countdown.
    assign jitter = lfsr_q[2:0];
`else
    assign jitter = 3'd0;
`endif

    mem_tag_tracker #(
        .NUM_TAGS (NUM_TAGS),
        .LATENCY  (LATENCY)
    ) u_tracker (
        .clk_i       (clock),
        .rst_i       (reset),
        .req_i       (cmd_valid),
        .jitter_i    (jitter),
        .grant_tag_o (grant_tag),
        .done_tag_o  (done_tag)
    );

    assign mem2proc_response = grant_tag;

    // Byte-lane store into the array at the accept edge; contents are never reset.
    always_ff @(posedge clock) begin
        if (accept && is_store && in_range) begin
            for (int b = 0; b < 8; b++) begin
                if (be[b]) begin
                    mem_q[mem_idx][b*8 +: 8] <= proc2mem_data[b*8 +: 8];
                end
            end
        end
    end

    // Loads snapshot the line at acceptance; stores park a zero return value.
    always_ff @(posedge clock) begin
        if (accept) begin
            slot_data_q[grant_tag] <= is_store ? '0 : rd_line;
        end
    end

    // Completion value for the next edge: the selected slot's tag and data.
    always_comb begin
        tag_d  = done_tag;
        data_d = '0;
        if (done_tag != '0) begin
            data_d = slot_data_q[done_tag];
        end
    end

    // Registered completion outputs, valid for exactly one cycle per tag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tag_q  <= '0;
            data_q <= '0;
        end else begin
            tag_q  <= tag_d;
            data_q <= data_d;
        end
    end

    assign mem2proc_tag  = tag_q;
    assign mem2proc_data = data_q;

endmodule
